sd_cmd_tx: RTL and testbench
============================

SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 SHALL have parameter HOLDOFF, default 8: number of bit times the line stays released after the end bit before done is signalled (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_strobe  input  1  one-clk pulse marking each SD CMD bit boundary (SDCLK falling edge).
REQ-005 SHALL have port start  input  1  request to send one command frame.
REQ-006 SHALL have port cmd_index  input  6  command index, sampled on accept.
REQ-007 SHALL have port cmd_arg  input  32  command argument, sampled on accept.
REQ-008 SHALL have port abort  input  1  synchronous abandon of any frame in progress.
REQ-009 SHALL have port cmd_out  output  1  serial CMD line data.
REQ-010 SHALL have port cmd_oe  output  1  CMD line output enable (1 = host drives).
REQ-011 SHALL have port busy  output  1  high from accept until done or abort.
REQ-012 SHALL have port done  output  1  one-clk completion pulse.

Function
REQ-013 SHALL implement states IDLE, SHIFT (frame bits 0..39), CRC (bits 40..46), END (bit 47), HOLD (HOLDOFF bit times released).
REQ-014 SHALL accept start only in IDLE with busy=0; start in any other state is ignored with no side effect.
REQ-015 SHALL, on the clk edge of accept, latch cmd_index/cmd_arg, clear the CRC7 accumulator, assert busy and cmd_oe, drive cmd_out=0 (bit 0), independent of bit_strobe.
REQ-016 SHALL transmit MSB first the 48-bit frame {1'b0, 1'b1, cmd_index[5:0], cmd_arg[31:0], crc7[6:0], 1'b1}.
REQ-017 SHALL hold each bit from its launch until the next bit_strobe, then advance exactly one bit per bit_strobe; no progress on clk cycles without bit_strobe.
REQ-018 SHALL compute crc7 with polynomial x^7+x^3+1, initial value 0, over frame bits 0..39 only, each bit accumulated on the bit_strobe that retires it.
REQ-019 SHALL output crc7 bits 6 down to 0 in CRC state without further accumulation, then the end bit 1 in END.
REQ-020 SHALL, on the bit_strobe retiring bit 47, deassert cmd_oe, set cmd_out=1, enter HOLD.
REQ-021 SHALL, in HOLD, count HOLDOFF bit_strobes; on the last, pulse done for one clk, clear busy, enter IDLE on the same edge.
REQ-022 SHALL permit a new start on the clk after done (back-to-back frames).
REQ-023 SHALL, on abort=1 in any state, go to IDLE on that edge: cmd_oe=0, cmd_out=1, busy=0, no done pulse.
REQ-024 SHALL give abort priority over start and bit_strobe when coincident; start coincident with abort in IDLE is not accepted.
REQ-025 SHALL treat bit_strobe coincident with accept as not advancing; bit 0 is held until the following bit_strobe.
REQ-026 SHALL keep cmd_out=1 whenever cmd_oe=0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force state IDLE, cmd_oe=0, cmd_out=1, busy=0, done=0, bit counter and CRC to 0.
REQ-028 SHALL, on reset_n assertion mid-frame, drop the frame immediately with no done pulse; after release, first start is accepted normally.

Verification
REQ-029 SHALL pass: CMD0, arg 0x00000000, strobe every 4 clk -> cmd_out sequence 0x40_00_00_00_00_95 MSB first, cmd_oe high 48 bit times, done one clk after 8 further strobes.
REQ-030 SHALL pass: CMD8, arg 0x000001AA -> frame 0x48_00_00_01_AA_87 (crc7 0x43).
REQ-031 SHALL pass: CMD17, arg 0x00000000, irregular bit_strobe spacing (1..7 clk) -> frame 0x51_00_00_00_00_55, bit values unchanged between strobes.
REQ-032 SHALL pass: start pulsed during SHIFT of CMD0 -> ignored; only one frame, one done.
REQ-033 SHALL pass: abort at bit 20 -> next clk cmd_oe=0, cmd_out=1, busy=0, no done; subsequent CMD0 frame correct (CRC 0x4A).
REQ-034 SHALL pass: reset_n low at bit 44 then released -> outputs at reset values immediately, no done, next CMD8 frame correct.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD host CMD-line serializer: sends one 48-bit command frame with CRC7, then releases the line.
// Latency: bit 0 on the line the clk after accept; one bit per bit_strobe; done HOLDOFF strobes after the end bit.
// Backpressure: start is only taken while idle (busy=0); abort drops the frame at once.
module sd_cmd_tx #(
  parameter int HOLDOFF = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_strobe,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        abort,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_CRC   = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic [2:0]  state;
  logic [39:0] sreg;      // remaining header/argument bits, MSB is the bit on the line
  logic [6:0]  crc;
  logic [6:0]  crc_next;
  logic        crc_fb;
  logic [5:0]  bit_cnt;   // index of the bit currently on the line
  logic [7:0]  hold_cnt;

  // CRC7 (x^7 + x^3 + 1) step for the bit that is about to retire.
  always_comb begin
    crc_fb   = sreg[39] ^ crc[6];
    crc_next = {crc[5], crc[4], crc[3], crc[2] ^ crc_fb, crc[1], crc[0], crc_fb};
  end

  // Frame sequencer: abort beats start and strobe; progress only on bit_strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      sreg     <= '0;
      crc      <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      cmd_out  <= 1'b1;
      cmd_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        cmd_oe  <= 1'b0;
        cmd_out <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !busy) begin
              // Accept: bit 0 (start bit) goes out now; a coincident strobe does not retire it.
              sreg     <= {2'b01, cmd_index, cmd_arg};
              crc      <= '0;
              bit_cnt  <= '0;
              hold_cnt <= '0;
              cmd_out  <= 1'b0;
              cmd_oe   <= 1'b1;
              busy     <= 1'b1;
              state    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (bit_strobe) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd39) begin
                // Last covered bit retires: crc is final, launch its MSB.
                crc     <= crc_next;
                cmd_out <= crc_next[6];
                state   <= S_CRC;
              end else begin
                crc     <= crc_next;
                sreg    <= {sreg[38:0], 1'b0};
                cmd_out <= sreg[38];
              end
            end
          end
          S_CRC: begin
            if (bit_strobe) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd46) begin
                cmd_out <= 1'b1;
                state   <= S_END;
              end else begin
                // Shift the finished crc out; no accumulation here.
                crc     <= {crc[5:0], 1'b0};
                cmd_out <= crc[5];
              end
            end
          end
          S_END: begin
            if (bit_strobe) begin
              cmd_oe   <= 1'b0;
              cmd_out  <= 1'b1;
              hold_cnt <= '0;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bit_strobe) begin
              if (hold_cnt == HOLD_LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: frame vectors, ignored start, abort and mid-frame reset.
// Expected frame bits are queued on start and popped each time a bit retires on the line.
// Strobe spacing is regular (every 4 clk) or random 1..7 clk.
module tb_sd_cmd_tx;

  localparam int HOLDOFF = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bit_strobe = 1'b0;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        abort;
  logic        cmd_out, cmd_oe, busy, done;

  sd_cmd_tx #(.HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset_n(reset_n), .bit_strobe(bit_strobe), .start(start),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .abort(abort),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];
  int n_oe_bits = 0;
  int unstable = 0;
  int inv_err = 0;
  int done_cnt = 0;
  int hold_mon = 0;
  logic prev_oe = 1'b0, prev_out = 1'b1, prev_strobe = 1'b0;
  int gap_mode = 0;

  typedef struct {
    string       name;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    int          gap;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC7 over the 40 covered frame bits.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) begin
      logic fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Strobe generator: gap_mode 0 = every 4 clk, 1 = random spacing 1..7 clk.
  initial begin
    int cnt = 2;
    forever begin
      @(posedge clk); #1;
      if (cnt == 0) begin
        bit_strobe = 1'b1;
        cnt = (gap_mode == 1) ? int'($urandom_range(0, 6)) : 3;
      end else begin
        bit_strobe = 1'b0;
        cnt--;
      end
    end
  end

  // Line monitor: scoreboard pop on each retiring bit, stability and release invariants.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!cmd_oe && cmd_out !== 1'b1) inv_err++;
      if (prev_oe && cmd_oe && !prev_strobe && cmd_out !== prev_out) unstable++;
      if (cmd_oe && bit_strobe) begin
        n_oe_bits++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_bit actual=%0b required=none", cmd_out);
        end else begin
          check("frame_bit", 64'(cmd_out), 64'(exp_q.pop_front()));
        end
      end
      if (cmd_oe) hold_mon = 0;
      else if (busy && bit_strobe) hold_mon++;
      if (done) begin
        done_cnt++;
        check("hold_strobes", 64'(hold_mon), 64'(HOLDOFF));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    prev_oe = cmd_oe;
    prev_out = cmd_out;
    prev_strobe = bit_strobe;
  end

  task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] frame);
    n_oe_bits = 0;
    unstable = 0;
    for (int i = 47; i >= 0; i--) exp_q.push_back(frame[i]);
    @(posedge clk); #1;
    start = 1'b1; cmd_index = idx; cmd_arg = arg;
    @(posedge clk); #1;
    start = 1'b0; cmd_index = ~idx; cmd_arg = $urandom;
    @(negedge clk);
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_oe", 64'(cmd_oe), 64'd1);
    check("accept_bit0", 64'(cmd_out), 64'd0);
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    @(negedge clk);
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_oe_bits"}, 64'(n_oe_bits), 64'd48);
    check({name, "_unstable"}, 64'(unstable), 64'd0);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (n_oe_bits >= n) break;
      @(negedge clk);
    end
    check("reach_bit", 64'(n_oe_bits >= n), 64'd1);
  endtask

  initial begin
    vec_t vecs[4];
    logic [39:0] hdr;
    int d0;

    vecs[0] = '{"cmd0",  6'd0,  32'h0000_0000, 48'h40_00_00_00_00_95, 0};
    vecs[1] = '{"cmd8",  6'd8,  32'h0000_01AA, 48'h48_00_00_01_AA_87, 0};
    vecs[2] = '{"cmd17", 6'd17, 32'h0000_0000, 48'h51_00_00_00_00_55, 1};
    hdr = {2'b01, 6'd55, 32'hDEAD_BEEF};
    vecs[3] = '{"cmd55", 6'd55, 32'hDEAD_BEEF, {hdr, ref_crc7(hdr), 1'b1}, 1};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_index = '0; cmd_arg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", 64'(cmd_oe), 64'd0);
    check("rst_out", 64'(cmd_out), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      gap_mode = vecs[v].gap;
      launch(vecs[v].idx, vecs[v].arg, vecs[v].frame);
      wait_done(vecs[v].name);
    end

    // Start during SHIFT must be ignored: one frame, one done.
    gap_mode = 0;
    d0 = done_cnt;
    launch(6'd0, 32'h0, 48'h40_00_00_00_00_95);
    wait_bits(10);
    @(posedge clk); #1;
    start = 1'b1; cmd_index = 6'd17; cmd_arg = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start");
    repeat (300) @(negedge clk);
    check("ignored_start_one_done", 64'(done_cnt - d0), 64'd1);
    check("ignored_start_no_frame", 64'(n_oe_bits), 64'd48);

    // Abort at bit 20, then a clean CMD0 frame.
    launch(6'd0, 32'h0, 48'h40_00_00_00_00_95);
    wait_bits(20);
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_oe", 64'(cmd_oe), 64'd0);
    check("abort_out", 64'(cmd_out), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (200) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_no_restart", 64'(cmd_oe), 64'd0);
    launch(6'd0, 32'h0, 48'h40_00_00_00_00_95);
    wait_done("after_abort");

    // Reset mid-frame at bit 44, then CMD8.
    launch(6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87);
    wait_bits(44);
    d0 = done_cnt;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_oe", 64'(cmd_oe), 64'd0);
    check("midrst_out", 64'(cmd_out), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    repeat (100) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    launch(6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87);
    wait_done("after_reset");

    check("released_line_high", 64'(inv_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
